vga_sig_gen: RTL

- Downstream consumer of the frame buffer read port (port B).
- Generates 640x480@60Hz VGA timing from the system clock and issues frame-buffer read addresses.
- Upscales the 160x120 1-bit image 4x in each axis and maps each bit to a foreground or background colour.
- Drives HS, VS and an 8-bit colour bus to the board DAC; the frame-buffer B_CLK is tied to CLK.

---
 rtl/vga_pkg.sv | 61 ++++++
 rtl/vga_pixel_counter.sv | 69 ++++++
 rtl/vga_sig_gen.sv | 134 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Package : vga_pkg
// Brief   : 640x480@60Hz timing constants, frame-buffer address layout and
//           the coordinate-to-address helper shared by the VGA generator.
// Rev     : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Default pixel-clock divider (100 MHz system clock -> 25 MHz pixels).
  localparam int DEF_CLK_DIV = 4;

  // Horizontal timing in pixels.
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  // Vertical timing in lines.
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Sync pulse boundaries (inclusive) derived from the default timing.
  localparam int DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
  localparam int DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

  // Counter width and frame-buffer address layout: {Y[6:0], X[7:0]}.
  localparam int CNT_W          = 10;
  localparam int FB_X_W         = 8;
  localparam int FB_Y_W         = 7;
  localparam int FB_ADDR_W      = FB_Y_W + FB_X_W;
  localparam int FB_SCALE_SHIFT = 2;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [FB_Y_W-1:0] y;
    logic [FB_X_W-1:0] x;
  } fb_addr_t;

  // Map a screen coordinate to the 4x-downscaled frame-buffer address.
  // Off-screen coordinates saturate to the last column/row so the address
  // never aliases (V[8:2] alone would wrap back to small rows in blanking).
  function automatic fb_addr_t fb_addr(input cnt_t h, input cnt_t v,
                                       input cnt_t h_vis, input cnt_t v_vis);
    fb_addr_t a;
    a.x = (h < h_vis) ? h[FB_X_W+1:FB_SCALE_SHIFT]
                      : FB_X_W'((h_vis >> FB_SCALE_SHIFT) - cnt_t'(1));
    a.y = (v < v_vis) ? v[FB_Y_W+1:FB_SCALE_SHIFT]
                      : FB_Y_W'((v_vis >> FB_SCALE_SHIFT) - cnt_t'(1));
    return a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pixel_counter.sv
`default_nettype none
// ============================================================================
// Module : vga_pixel_counter
// Brief  : Pixel-clock divider plus horizontal/vertical scan counters.
//          Emits the pixel tick, the current (H,V) and a one-cycle wrap pulse
//          on the tick that moves the scan from the last pixel back to (0,0).
// Rev    : 1.0 - initial release
// ============================================================================
module vga_pixel_counter
  import vga_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int H_TOTAL = DEF_H_TOTAL,
  parameter int V_TOTAL = DEF_V_TOTAL
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             pix_tick,
  output logic [CNT_W-1:0] h,
  output logic [CNT_W-1:0] v,
  output logic             wrap
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam cnt_t             H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t             V_LAST   = cnt_t'(V_TOTAL - 1);

  logic [DIV_W-1:0] div;
  logic             h_last;
  logic             v_last;

  assign pix_tick = (div == DIV_LAST);
  assign h_last   = (h == H_LAST);
  assign v_last   = (v == V_LAST);
  assign wrap     = pix_tick && h_last && v_last;

  // Divider: counts 0..CLK_DIV-1, the last count marks the pixel boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (pix_tick) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Scan counters: H advances each pixel, V advances when H wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (pix_tick) begin
      if (h_last) begin
        h <= '0;
        if (v_last) begin
          v <= '0;
        end else begin
          v <= v + cnt_t'(1);
        end
      end else begin
        h <= h + cnt_t'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_sig_gen.sv
`default_nettype none
// ============================================================================
// Module : vga_sig_gen
// Brief  : VGA timing generator reading a 160x120 1-bit frame buffer,
//          upscaled 4x, with per-frame latched foreground/background colours.
//          Optional feature macro: VGA_BORDER_EN (forces a white 1-pixel
//          border around the visible area as a screen-alignment aid).
// Rev    : 1.0 - initial release
// ============================================================================
module vga_sig_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [15:0]          CONFIG_COLOURS,
  input  logic                 VGA_DATA,
  output logic [FB_ADDR_W-1:0] VGA_ADDR,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic [7:0]           VGA_COLOUR,
  output logic                 FRAME_START
);

  localparam int   H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam cnt_t H_VIS    = cnt_t'(H_VISIBLE);
  localparam cnt_t V_VIS    = cnt_t'(V_VISIBLE);
  localparam cnt_t HS_START = cnt_t'(H_VISIBLE + H_FP);
  localparam cnt_t HS_END   = cnt_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam cnt_t VS_START = cnt_t'(V_VISIBLE + V_FP);
  localparam cnt_t VS_END   = cnt_t'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic        pix_tick;
  logic        wrap;
  cnt_t        h;
  cnt_t        v;
  fb_addr_t    addr_q;
  logic [15:0] colours_q;
  logic        visible;
  logic        hs_next;
  logic        vs_next;
  logic [7:0]  colour_next;

  vga_pixel_counter #(
    .CLK_DIV (CLK_DIV),
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_counter (
    .clk      (CLK),
    .rst_n    (RESET),
    .pix_tick (pix_tick),
    .h        (h),
    .v        (v),
    .wrap     (wrap)
  );

  // Frame-buffer read address, refreshed every clock from the live counters.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      addr_q <= '0;
    end else begin
      addr_q <= fb_addr(h, v, H_VIS, V_VIS);
    end
  end

  assign VGA_ADDR = addr_q;

  // Colours only change at the frame wrap so a frame is never drawn in two palettes.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      colours_q <= 16'h0000;
    end else if (wrap) begin
      colours_q <= CONFIG_COLOURS;
    end
  end

  // One-clock frame marker aligned with the wrap edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      FRAME_START <= 1'b0;
    end else begin
      FRAME_START <= wrap;
    end
  end

  assign visible = (h < H_VIS) && (v < V_VIS);

`ifdef VGA_BORDER_EN
  logic on_border;
  assign on_border = (h == '0) || (h == H_VIS - cnt_t'(1)) ||
                     (v == '0) || (v == V_VIS - cnt_t'(1));
`endif

  // Decode sync and colour for the pixel currently held by the counters.
  always_comb begin
    hs_next     = !((h >= HS_START) && (h <= HS_END));
    vs_next     = !((v >= VS_START) && (v <= VS_END));
    colour_next = 8'h00;
    if (visible) begin
      colour_next = VGA_DATA ? colours_q[15:8] : colours_q[7:0];
`ifdef VGA_BORDER_EN
      if (on_border) begin
        colour_next = 8'hFF;
      end
`endif
    end
  end

  // Output stage: all three outputs share a one-pixel latency. VGA_DATA has
  // settled by the tick because address and buffer each take one clock.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      VGA_HS     <= 1'b1;
      VGA_VS     <= 1'b1;
      VGA_COLOUR <= 8'h00;
    end else if (pix_tick) begin
      VGA_HS     <= hs_next;
      VGA_VS     <= vs_next;
      VGA_COLOUR <= colour_next;
    end
  end

endmodule
`default_nettype wire
